// File: rtl/display_scanner_if.sv
// Scanner bus: memory read port, bank swap handshake and HUB75 panel pins.
// The scanner is the master; memory, writer and panel together are the slave.
interface display_scanner_if #(
    parameter int segments = 1,
    parameter int rows     = 8,
    parameter int columns  = 32,
    parameter int width    = 24
);
    logic                        swap_req;
    logic                        swap_ack;
    logic                        flip;
    logic [$clog2(rows)-1:0]     rrow;
    logic [$clog2(columns)-1:0]  rcol;
    logic [width*segments-1:0]   rdata;
    logic                        panel_clk;
    logic                        panel_lat;
    logic                        panel_oe;
    logic [$clog2(rows)-1:0]     panel_addr;
    logic [3*segments-1:0]       panel_rgb;

    modport master (
        input  swap_req, rdata,
        output swap_ack, flip, rrow, rcol,
        output panel_clk, panel_lat, panel_oe, panel_addr, panel_rgb
    );

    modport slave (
        output swap_req, rdata,
        input  swap_ack, flip, rrow, rcol,
        input  panel_clk, panel_lat, panel_oe, panel_addr, panel_rgb
    );
endinterface

// File: rtl/display_scanner.sv
// Scans the displayed bank row by row and bit-plane by bit-plane onto a HUB75
// panel with binary-coded modulation, and flips banks at frame boundaries.
module display_scanner #(
    parameter int segments  = 1,
    parameter int rows      = 8,
    parameter int columns   = 32,
    parameter int width     = 24,
    parameter int base_time = 4
) (
    input  logic              clk,
    input  logic              rst,
    display_scanner_if.master bus
);
    localparam int depth   = width / 3;
    localparam int row_w   = $clog2(rows);
    localparam int col_w   = $clog2(columns);
    localparam int slot_w  = $clog2(columns + 1);
    localparam int plane_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int time_w  = $clog2((base_time << (depth - 1)) + 1);

    localparam logic [slot_w-1:0]  last_slot  = slot_w'(columns);
    localparam logic [slot_w-1:0]  last_read  = slot_w'(columns - 1);
    localparam logic [row_w-1:0]   last_row   = row_w'(rows - 1);
    localparam logic [plane_w-1:0] last_plane = plane_w'(depth - 1);

    typedef enum logic [1:0] {SHIFT, LATCH, DISPLAY, FRAME} state_t;

    state_t                state_reg;
    logic [row_w-1:0]      row_reg;
    logic [plane_w-1:0]    plane_reg;
    logic [slot_w-1:0]     slot_reg;
    logic                  phase_reg;
    logic [time_w-1:0]     timer_reg;
    logic                  pending_reg;

    logic                  flip_reg;
    logic                  swap_ack_reg;
    logic [row_w-1:0]      rrow_reg;
    logic [col_w-1:0]      rcol_reg;
    logic                  panel_clk_reg;
    logic                  panel_lat_reg;
    logic                  panel_oe_reg;
    logic [row_w-1:0]      panel_addr_reg;
    logic [3*segments-1:0] panel_rgb_reg;

    logic [3*segments-1:0] lane_bits;
    logic [time_w-1:0]     plane_time;

    assign plane_time = time_w'(base_time) << plane_reg;

    // Current plane's bit of R, G and B for every lane of the read word.
    genvar gi;
    generate
        for (gi = 0; gi < segments; gi++) begin : g_lane
            logic [depth-1:0] red;
            logic [depth-1:0] green;
            logic [depth-1:0] blue;
            assign red   = bus.rdata[width*gi + 2*depth +: depth];
            assign green = bus.rdata[width*gi + depth +: depth];
            assign blue  = bus.rdata[width*gi +: depth];
            assign lane_bits[3*gi +: 3] = {red[plane_reg], green[plane_reg], blue[plane_reg]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= SHIFT;
            row_reg        <= '0;
            plane_reg      <= '0;
            slot_reg       <= '0;
            phase_reg      <= 1'b0;
            timer_reg      <= '0;
            pending_reg    <= 1'b0;
            flip_reg       <= 1'b0;
            swap_ack_reg   <= 1'b0;
            rrow_reg       <= '0;
            rcol_reg       <= '0;
            panel_clk_reg  <= 1'b0;
            panel_lat_reg  <= 1'b0;
            panel_oe_reg   <= 1'b1;
            panel_addr_reg <= '0;
            panel_rgb_reg  <= '0;
        end else begin
            swap_ack_reg <= 1'b0;
            if (bus.swap_req && !swap_ack_reg) begin
                pending_reg <= 1'b1;
            end
            case (state_reg)
                SHIFT: begin
                    if (!phase_reg) begin
                        phase_reg     <= 1'b1;
                        panel_clk_reg <= (slot_reg != '0);
                    end else begin
                        phase_reg     <= 1'b0;
                        panel_clk_reg <= 1'b0;
                        if (slot_reg == last_slot) begin
                            state_reg      <= LATCH;
                            slot_reg       <= '0;
                            panel_lat_reg  <= 1'b1;
                            panel_addr_reg <= row_reg;
                        end else begin
                            // Read data for this slot arrived during phase 1.
                            panel_rgb_reg <= lane_bits;
                            slot_reg      <= slot_reg + 1'b1;
                            if (slot_reg < last_read) begin
                                rcol_reg <= rcol_reg + 1'b1;
                            end
                        end
                    end
                end
                LATCH: begin
                    state_reg     <= DISPLAY;
                    panel_lat_reg <= 1'b0;
                    panel_oe_reg  <= 1'b0;
                    timer_reg     <= plane_time - 1'b1;
                end
                DISPLAY: begin
                    if (timer_reg != '0) begin
                        timer_reg <= timer_reg - 1'b1;
                    end else begin
                        panel_oe_reg <= 1'b1;
                        rcol_reg     <= '0;
                        if (plane_reg != last_plane) begin
                            plane_reg <= plane_reg + 1'b1;
                            state_reg <= SHIFT;
                        end else if (row_reg != last_row) begin
                            plane_reg <= '0;
                            row_reg   <= row_reg + 1'b1;
                            rrow_reg  <= row_reg + 1'b1;
                            state_reg <= SHIFT;
                        end else begin
                            state_reg <= FRAME;
                            // A request arriving in this very cycle still makes this frame.
                            if (pending_reg || bus.swap_req) begin
                                flip_reg     <= ~flip_reg;
                                swap_ack_reg <= 1'b1;
                                pending_reg  <= 1'b0;
                            end
                        end
                    end
                end
                FRAME: begin
                    state_reg <= SHIFT;
                    row_reg   <= '0;
                    plane_reg <= '0;
                    rrow_reg  <= '0;
                    rcol_reg  <= '0;
                end
                default: state_reg <= SHIFT;
            endcase
        end
    end

    assign bus.flip       = flip_reg;
    assign bus.swap_ack   = swap_ack_reg;
    assign bus.rrow       = rrow_reg;
    assign bus.rcol       = rcol_reg;
    assign bus.panel_clk  = panel_clk_reg;
    assign bus.panel_lat  = panel_lat_reg;
    assign bus.panel_oe   = panel_oe_reg;
    assign bus.panel_addr = panel_addr_reg;
    assign bus.panel_rgb  = panel_rgb_reg;
endmodule

// File: tb/tb_display_scanner.sv
// Scoreboard bench: frame-level reference events (shift pixel, latch, display
// run, swap ack) are queued and matched against a negedge panel monitor.
module tb_display_scanner;
    localparam int SEG       = 1;
    localparam int ROWS      = 8;
    localparam int COLS      = 32;
    localparam int WIDTH     = 24;
    localparam int BT        = 4;
    localparam int DEPTH     = WIDTH / 3;
    localparam int PLANE_FIX = 2 * (COLS + 1) + 1;

    typedef enum int {EV_SHIFT, EV_LATCH, EV_DISP, EV_ACK} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cycle;
        int       value;
    } ev_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    display_scanner_if #(.segments(SEG), .rows(ROWS), .columns(COLS), .width(WIDTH)) bus ();
    display_scanner #(.segments(SEG), .rows(ROWS), .columns(COLS), .width(WIDTH), .base_time(BT)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Two-lane instance with a constant word: lane 1 all ones, lane 0 all zeros.
    display_scanner_if #(.segments(2), .rows(2), .columns(4), .width(24)) bus2 ();
    display_scanner #(.segments(2), .rows(2), .columns(4), .width(24), .base_time(1)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2)
    );
    assign bus2.rdata    = {24'hFFFFFF, 24'h000000};
    assign bus2.swap_req = 1'b0;

    logic [WIDTH*SEG-1:0] mem [2][ROWS][COLS];
    ev_t  exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   seg2_shifts = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
    always @(posedge clk) bus.rdata <= mem[bus.flip][bus.rrow][bus.rcol];

    function automatic int plane_len(input int b);
        return PLANE_FIX + (BT << b);
    endfunction

    function automatic int row_len();
        int n = 0;
        for (int b = 0; b < DEPTH; b++) n += plane_len(b);
        return n;
    endfunction

    function automatic int frame_len();
        return ROWS * row_len() + 1;
    endfunction

    function automatic int exp_rgb(input int bank, input int r, input int k, input int b);
        logic [WIDTH*SEG-1:0] word;
        logic [WIDTH-1:0]     lane;
        int v = 0;
        int t;
        word = mem[bank][r][k];
        for (int s = 0; s < SEG; s++) begin
            lane = word[WIDTH*s +: WIDTH];
            t = {29'd0, lane[2*DEPTH + b], lane[DEPTH + b], lane[b]};
            v |= t << (3 * s);
        end
        return v;
    endfunction

    task automatic push_ev(input ev_kind_t kind, input int cycle, input int value);
        ev_t e;
        e.kind  = kind;
        e.cycle = cycle;
        e.value = value;
        exp_q.push_back(e);
    endtask

    // Every event one displayed frame produces, in order, with absolute cycle.
    task automatic push_frame(input int start, input int bank, input bit ack);
        int t = start;
        for (int r = 0; r < ROWS; r++) begin
            for (int b = 0; b < DEPTH; b++) begin
                for (int k = 0; k < COLS; k++) push_ev(EV_SHIFT, t + 2 * k + 3, exp_rgb(bank, r, k, b));
                push_ev(EV_LATCH, t + PLANE_FIX - 1, r);
                push_ev(EV_DISP, t + PLANE_FIX, BT << b);
                t += plane_len(b);
            end
        end
        if (ack) push_ev(EV_ACK, t, 1);
    endtask

    task automatic got(input ev_kind_t kind, input int cycle, input int value);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_%s: got cycle %0d value %0d, required no event", kind.name(), cycle, value);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.cycle != cycle || e.value != value) begin
            errors++;
            $display("FAIL event_%s: got %s cycle %0d value %0d, required %s cycle %0d value %0d",
                     e.kind.name(), kind.name(), cycle, value, e.kind.name(), e.cycle, e.value);
        end else begin
            $display("ok %s cycle %0d value %0d", kind.name(), cycle, value);
        end
    endtask

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, actual, expected, cyc);
        end else begin
            $display("ok %s = %0h (cycle %0d)", name, actual, cyc);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    // Panel monitor: shift clocks, latch pulses, output-enable runs, swap acks.
    initial begin
        bit oe_low = 1'b0;
        int run_start = 0;
        int run_len = 0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                oe_low = 1'b0;
            end else begin
                if (bus.panel_oe === 1'b0) begin
                    if (!oe_low) begin
                        oe_low    = 1'b1;
                        run_start = cyc;
                        run_len   = 0;
                    end
                    run_len++;
                end else if (oe_low) begin
                    oe_low = 1'b0;
                    got(EV_DISP, run_start, run_len);
                end
                if (bus.panel_clk === 1'b1) got(EV_SHIFT, cyc, int'(bus.panel_rgb));
                if (bus.panel_lat === 1'b1) got(EV_LATCH, cyc, int'(bus.panel_addr));
                if (bus.swap_ack === 1'b1) got(EV_ACK, cyc, int'(bus.flip));
            end
            if (rst === 1'b0 && bus2.panel_clk === 1'b1) begin
                checks++;
                seg2_shifts++;
                if (bus2.panel_rgb !== 6'b111000) begin
                    errors++;
                    $display("FAIL seg2_rgb: got %b required 111000 (cycle %0d)", bus2.panel_rgb, cyc);
                end else begin
                    $display("ok seg2_rgb %b cycle %0d", bus2.panel_rgb, cyc);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_flip"},       bus.flip,       0);
        chk({tag, "_swap_ack"},   bus.swap_ack,   0);
        chk({tag, "_rrow"},       bus.rrow,       0);
        chk({tag, "_rcol"},       bus.rcol,       0);
        chk({tag, "_panel_clk"},  bus.panel_clk,  0);
        chk({tag, "_panel_lat"},  bus.panel_lat,  0);
        chk({tag, "_panel_oe"},   bus.panel_oe,   1);
        chk({tag, "_panel_addr"}, bus.panel_addr, 0);
        chk({tag, "_panel_rgb"},  bus.panel_rgb,  0);
    endtask

    initial begin
        int fl;
        int t_mid;
        rst = 1'b1;
        bus.swap_req = 1'b0;
        fl = frame_len();
        for (int bk = 0; bk < 2; bk++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    mem[bk][r][c] = (WIDTH*SEG)'($urandom);
        // Row 0 of bank 0: only red bit 0 of column 0 is set.
        for (int c = 0; c < COLS; c++) mem[0][0][c] = (c == 0) ? 24'h010000 : 24'h000000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1 rst = 1'b0;
        push_frame(0, 0, 1'b1);
        push_frame(fl, 1, 1'b0);
        mon_en = 1'b1;
        @(negedge clk);
        chk("rcol_cycle0", bus.rcol, 0);

        wait_cyc(100);
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;

        wait_cyc(fl - 2);
        chk("flip_before_swap", bus.flip, 0);
        chk("ack_before_swap", bus.swap_ack, 0);
        wait_cyc(fl - 1);
        chk("flip_at_swap", bus.flip, 1);
        chk("ack_at_swap", bus.swap_ack, 1);
        wait_cyc(fl);
        chk("ack_one_cycle", bus.swap_ack, 0);
        push_frame(2 * fl, 1, 1'b0);

        wait_cyc(2 * fl - 1);
        chk("flip_no_second_swap", bus.flip, 1);
        chk("ack_no_second_swap", bus.swap_ack, 0);
        wait_cyc(2 * fl);
        chk("no_stale_events", (exp_q.size() > 0) ? (exp_q[0].cycle >= 2 * fl) : 1'b0, 1);

        wait_cyc(2 * fl + 50);
        bus.swap_req = 1'b1;
        @(negedge clk);
        bus.swap_req = 1'b0;

        // Land inside the plane-5 display period of row 3, then reset.
        t_mid = 2 * fl + 3 * row_len() + PLANE_FIX + 10;
        for (int b = 0; b < 5; b++) t_mid += plane_len(b);
        wait_cyc(t_mid);
        mon_en = 1'b0;
        exp_q.delete();
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("midreset");
        rst = 1'b0;
        push_frame(0, 0, 1'b0);
        mon_en = 1'b1;

        wait_cyc(fl - 1);
        chk("pending_cleared_flip", bus.flip, 0);
        chk("pending_cleared_ack", bus.swap_ack, 0);
        wait_cyc(fl);
        chk("queue_drained", exp_q.size(), 0);
        chk("seg2_activity", seg2_shifts >= 100, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/display_scanner.md
# display_scanner

Read-side companion to the double-buffered display memory. It walks the displayed bank row by row and bit-plane by bit-plane, issuing read addresses into the memory's registered read port. It serialises pixel bits onto a HUB75-style LED panel interface (shift clock, latch, output-enable, row address) using binary-coded modulation. It also owns the bank `flip` signal and swaps banks only at a frame boundary when the write side requests it.

## Interface
- `segments`, 1: parallel pixel lanes per memory word, one RGB triple per lane.
- `rows`, 8: scan rows; also the panel address range.
- `columns`, 32: pixels shifted per row.
- `width`, 24: bits per lane; R=[23:16], G=[15:8], B=[7:0]; bit depth = width/3.
- `base_time`, 4: display cycles for plane 0; plane b displays `base_time << b` cycles.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `swap_req` in 1: write side requests a bank swap.
- `swap_ack` out 1: one-cycle pulse; bank swapped.
- `flip` out 1: bank select to memory; reader uses bank `flip`, writer uses `!flip`.
- `rrow` out $clog2(rows): memory read row.
- `rcol` out $clog2(columns): memory read column.
- `rdata` in width*segments: memory read data, valid the cycle after the address.
- `panel_clk` out 1: shift clock; panel samples on the rising edge.
- `panel_lat` out 1: latch pulse.
- `panel_oe` out 1: output enable, active low.
- `panel_addr` out $clog2(rows): panel row address.
- `panel_rgb` out 3*segments: lane s drives bits [3s+2:3s] = {R,G,B}.

## Operation
- States: SHIFT, LATCH, DISPLAY, FRAME.
- Counters:
  - row r: 0..rows-1.
  - plane b: 0..width/3-1.
  - slot k: 0..columns.
  - phase p: 0/1.
  - display timer.
- SHIFT, with `panel_oe`=1 throughout:
  - Each slot takes 2 cycles.
  - `rrow`=r; `rcol`=k during slot k (k<columns).
  - At the end of phase 1 of slot k (k<columns), `panel_rgb` is registered from `rdata`. Lane s takes bit b of R, G and B of `rdata[width*s +: width]`.
  - `panel_clk`=1 during phase 1 of slots 1..columns, which clocks column k-1. It is 0 otherwise.
  - Slot `columns` is a flush slot and issues no new read.
  - After slot `columns` phase 1, go to LATCH.
- LATCH: one cycle with `panel_lat`=1 and `panel_addr`=r (registered on entry).
- DISPLAY: `panel_oe`=0 for exactly `base_time << b` cycles. Then:
  - If b is not the last plane: b+1, go to SHIFT.
  - Else if r is not the last row: b=0, r+1, go to SHIFT.
  - Else go to FRAME.
- FRAME: one cycle with `panel_oe`=1. If a swap is pending, toggle `flip`, pulse `swap_ack`, and clear pending. Then r=0, b=0, go to SHIFT.
- Swap pending:
  - Set by `swap_req`=1 in any cycle except the cycle in which `swap_ack` is asserted; a request in that cycle is ignored.
  - Multiple requests within one frame produce one swap.
  - The writer deasserts `swap_req` after seeing `swap_ack`.
- Widths: all counters wrap only via explicit compare; no modular overflow is relied upon.

## Timing
- Reset values, applied the cycle after `rst` is sampled high (also when reset arrives mid-operation):
  - state SHIFT, slot 0 phase 0, r=0, b=0, pending=0.
  - `flip`=0, `swap_ack`=0, `rrow`=0, `rcol`=0.
  - `panel_clk`=0, `panel_lat`=0, `panel_oe`=1, `panel_addr`=0, `panel_rgb`=0.
- Memory read latency is 1 cycle and is absorbed by the 2-cycle slot.
- `panel_rgb` changes only at the start of phase 0. It is stable for a full cycle before and during the `panel_clk` high cycle.
- Plane length: 2*(columns+1) + 1 + (base_time << b) cycles.
- Frame length: rows × Σ_b(plane length) + 1.
  - Defaults: 8 × (8·67 + 4·255) + 1 = 12449 cycles.
- `flip` and `swap_ack` change in the same cycle: the FRAME cycle, cycle 12448 after reset release with defaults.
- The new bank's first read is in the next cycle.

## Test plan
- Reset: hold `rst` 3 cycles → all outputs at their reset values; release → `rcol`=0, `panel_clk` low for 2 cycles, first `panel_clk` high at cycle 3.
- Shift data: column 0 = 24'h010000, others 0 → in plane 0 of row 0, `panel_rgb`=3'b100 only on the first `panel_clk` high; plane 1 shows 3'b000.
- Plane timing: defaults → `panel_lat` high cycle 66; `panel_oe` low cycles 67–70 (plane 0); plane 3 `panel_oe` low exactly 32 cycles.
- Swap: pulse `swap_req` at cycle 100 → `flip` 0→1 and `swap_ack` high only at cycle 12448; no further request → `flip` unchanged at cycle 24897.
- Reset mid-DISPLAY at plane 5, row 3 → next cycle `panel_oe`=1, r=0, b=0, `flip`=0, pending cleared.
- segments=2, lane 1 = 24'hFFFFFF, lane 0 = 0 → `panel_rgb`=6'b111000 on every column of every plane.
